// File: rtl/mips_pkg.sv
// mips_pkg: shared register-index width, scoreboard entry type and stall count type.
package mips_pkg;
  localparam int REGISTERWIDTH = 5;
  typedef struct packed {
    logic                     vld;
    logic [REGISTERWIDTH-1:0] rd;
  } rd_entry_t;
  localparam rd_entry_t RD_BUBBLE = '{vld: 1'b0, rd: '0};
  typedef logic [1:0] stall_cnt_t;
endpackage

// File: rtl/rd_stall_ctrl.sv
// rd_stall_ctrl: stall counter and stall output; STALL_PERF_EN adds a saturating stall-cycle counter.
module rd_stall_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_in,
  input  stall_cnt_t  count_in,
  input  logic        flush,
  output logic        stall,
  output stall_cnt_t  stall_cnt,
  output logic [31:0] perf_stall_cycles
);
  stall_cnt_t cnt_q, cnt_d;
  // once the counter is running it owns the stall and hazard_in is ignored
  always_comb begin
    stall = rst_n & ((cnt_q != '0) | hazard_in);
    cnt_d = flush ? '0 : (cnt_q != '0) ? cnt_q - 2'd1 : (hazard_in && count_in != '0) ? count_in - 2'd1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign stall_cnt = cnt_q;
`ifdef STALL_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= '0;
    else if (stall && !flush && perf_q != '1) perf_q <= perf_q + 32'd1;
  end
  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif
endmodule

// File: rtl/rd_scoreboard.sv
// rd_scoreboard: shift buffer of in-flight destination registers (slot 0 = EX) feeding the hazard detector.
// Optional macro STALL_PERF_EN enables perf_stall_cycles; RD_W must not exceed REGISTERWIDTH.
module rd_scoreboard
  import mips_pkg::*;
#(
  parameter int RD_W  = REGISTERWIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic                       issue_wr,
  input  logic [RD_W-1:0]            issue_rd,
  input  logic                       hazard_in,
  input  logic [1:0]                 count_in,
  input  logic                       flush,
  output logic [DEPTH-1:0][RD_W-1:0] rd_buf,
  output logic [DEPTH-1:0]           rd_vld,
  output logic                       stall,
  output logic [1:0]                 stall_cnt,
  output logic [31:0]                perf_stall_cycles
);
  rd_entry_t [DEPTH-1:0] slot_q, slot_d;
  rd_entry_t push_e;
  rd_stall_ctrl u_ctrl (
    .clk               (clk),
    .rst_n             (rst_n),
    .hazard_in         (hazard_in),
    .count_in          (count_in),
    .flush             (flush),
    .stall             (stall),
    .stall_cnt         (stall_cnt),
    .perf_stall_cycles (perf_stall_cycles)
  );
  // R0 writes and non-writers carry no dependency, so they enter as bubbles
  always_comb begin
    push_e = (issue_valid && issue_wr && !stall && issue_rd != '0) ? '{vld: 1'b1, rd: REGISTERWIDTH'(issue_rd)} : RD_BUBBLE;
    slot_d = flush ? {DEPTH{RD_BUBBLE}} : {slot_q[DEPTH-2:0], push_e};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= {DEPTH{RD_BUBBLE}};
    else slot_q <= slot_d;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_out
    assign rd_buf[i] = RD_W'(slot_q[i].rd);
    assign rd_vld[i] = slot_q[i].vld;
  end
endmodule

// File: tb/tb_rd_scoreboard.sv
// tb_rd_scoreboard: directed vector table, perf/flush sequence and random run against a queue model.
module tb_rd_scoreboard;
  logic            clk = 0;
  logic            rst_n, issue_valid, issue_wr, hazard_in, flush;
  logic [4:0]      issue_rd;
  logic [1:0]      count_in, stall_cnt;
  logic [1:0][4:0] rd_buf;
  logic [1:0]      rd_vld;
  logic            stall;
  logic [31:0]     perf_stall_cycles;
  int n_chk = 0, n_fail = 0;

  rd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .hazard_in(hazard_in), .count_in(count_in), .flush(flush), .rd_buf(rd_buf), .rd_vld(rd_vld),
    .stall(stall), .stall_cnt(stall_cnt), .perf_stall_cycles(perf_stall_cycles)
  );
  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit iv; bit iw; bit [4:0] rd; bit hz; bit [1:0] cin; bit fl;
    bit e_stall; bit [1:0] e_vld; bit [4:0] e_rd0; bit [4:0] e_rd1; bit [1:0] e_cnt;
  } vec_t;
  typedef struct { bit vld; int rd; } ent_t;

  ent_t mq[$];
  int   mcnt;
  longint mperf;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic longint exp_perf();
`ifdef STALL_PERF_EN
    return mperf;
`else
    return 0;
`endif
  endfunction

  task automatic step(input vec_t v, input bit tbl);
    bit m_stall, push;
    ent_t e;
    rst_n = v.rst; issue_valid = v.iv; issue_wr = v.iw; issue_rd = v.rd;
    hazard_in = v.hz; count_in = v.cin; flush = v.fl;
    #1;
    m_stall = v.rst && (mcnt > 0 || v.hz);
    check("stall", {31'd0, stall}, {31'd0, m_stall});
    if (tbl) check("tbl_stall", {31'd0, stall}, {31'd0, v.e_stall});
    if (!v.rst) begin
      mq = '{'{0, 0}, '{0, 0}}; mcnt = 0; mperf = 0;
    end else begin
      if (m_stall && !v.fl && mperf < 64'hFFFFFFFF) mperf++;
      if (v.fl) begin
        mq = '{'{0, 0}, '{0, 0}}; mcnt = 0;
      end else begin
        mcnt = mcnt > 0 ? mcnt - 1 : v.hz ? (v.cin > 0 ? int'(v.cin) - 1 : 0) : 0;
        push = v.iv && v.iw && !m_stall && v.rd != 0;
        e.vld = push; e.rd = push ? int'(v.rd) : 0;
        mq.push_front(e);
        void'(mq.pop_back());
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("vld%0d", i), {31'd0, rd_vld[i]}, {31'd0, mq[i].vld});
      check($sformatf("rd%0d", i), {27'd0, rd_buf[i]}, mq[i].rd);
    end
    check("cnt", {30'd0, stall_cnt}, mcnt);
    check("perf", perf_stall_cycles, 32'(exp_perf()));
    if (tbl) begin
      check("tbl_vld", {30'd0, rd_vld}, {30'd0, v.e_vld});
      check("tbl_rd0", {27'd0, rd_buf[0]}, {27'd0, v.e_rd0});
      check("tbl_rd1", {27'd0, rd_buf[1]}, {27'd0, v.e_rd1});
      check("tbl_cnt", {30'd0, stall_cnt}, {30'd0, v.e_cnt});
    end
  endtask

  vec_t tv[22];
  vec_t rv;

  initial begin
    mq = '{'{0, 0}, '{0, 0}}; mcnt = 0; mperf = 0;
    rst_n = 0; issue_valid = 0; issue_wr = 0; issue_rd = 0; hazard_in = 0; count_in = 0; flush = 0;
    //       rst iv iw rd hz cin fl | stall vld    rd0 rd1 cnt
    tv[0]  = '{0, 1, 1, 7, 0, 0, 0,  0, 2'b00, 0, 0, 0};
    tv[1]  = '{0, 1, 1, 7, 0, 0, 0,  0, 2'b00, 0, 0, 0};
    tv[2]  = '{1, 1, 1, 5, 0, 0, 0,  0, 2'b01, 5, 0, 0};
    tv[3]  = '{1, 1, 1, 9, 0, 0, 0,  0, 2'b11, 9, 5, 0};
    tv[4]  = '{1, 0, 0, 0, 0, 0, 0,  0, 2'b10, 0, 9, 0};
    tv[5]  = '{1, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 0};
    tv[6]  = '{1, 1, 1, 4, 1, 2, 0,  1, 2'b00, 0, 0, 1};
    tv[7]  = '{1, 1, 1, 4, 1, 2, 0,  1, 2'b00, 0, 0, 0};
    tv[8]  = '{1, 1, 1, 4, 0, 0, 0,  0, 2'b01, 4, 0, 0};
    tv[9]  = '{1, 1, 1, 6, 1, 1, 0,  1, 2'b10, 0, 4, 0};
    tv[10] = '{1, 1, 1, 6, 0, 0, 0,  0, 2'b01, 6, 0, 0};
    tv[11] = '{1, 1, 1, 0, 0, 0, 0,  0, 2'b10, 0, 6, 0};
    tv[12] = '{1, 1, 0, 3, 0, 0, 0,  0, 2'b00, 0, 0, 0};
    tv[13] = '{1, 1, 1, 1, 0, 0, 0,  0, 2'b01, 1, 0, 0};
    tv[14] = '{1, 1, 1, 2, 0, 0, 0,  0, 2'b11, 2, 1, 0};
    tv[15] = '{1, 1, 1, 3, 1, 2, 0,  1, 2'b10, 0, 2, 1};
    tv[16] = '{1, 1, 1, 3, 0, 0, 1,  1, 2'b00, 0, 0, 0};
    tv[17] = '{1, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 0};
    tv[18] = '{1, 1, 1, 5, 1, 0, 0,  1, 2'b00, 0, 0, 0};
    tv[19] = '{1, 1, 1, 5, 0, 0, 0,  0, 2'b01, 5, 0, 0};
    tv[20] = '{1, 0, 0, 0, 1, 2, 0,  1, 2'b10, 0, 5, 1};
    tv[21] = '{0, 1, 1, 8, 1, 2, 0,  0, 2'b00, 0, 0, 0};
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) step(tv[i], 1);
    // fill, stall on an EX hazard, flush while stall_cnt=1: only the first stall cycle counts
    step('{1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0}, 0);
    step('{1, 1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0}, 0);
    step('{1, 1, 1, 12, 1, 2, 0, 0, 0, 0, 0, 0}, 0);
    step('{1, 1, 1, 12, 0, 0, 1, 0, 0, 0, 0, 0}, 0);
`ifdef STALL_PERF_EN
    check("perf_flush", perf_stall_cycles, 32'd1);
`else
    check("perf_flush", perf_stall_cycles, 32'd0);
`endif
    check("flush_vld", {30'd0, rd_vld}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      rv = '{$urandom_range(0, 99) > 2, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             5'($urandom_range(0, 31)), $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
             $urandom_range(0, 9) == 0, 0, 0, 0, 0, 0};
      step(rv, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
